// File: rtl/sram_bus_arbiter.sv
// Two-master SRAM-like bus arbiter with grant lock and in-order owner FIFO for responses.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed m1-over-m0 priority for round-robin.
module sram_bus_arbiter #(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned OWN_W     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        busy
);

    localparam logic [OWN_W:0] FullCnt = (OWN_W+1)'(MAX_OUTST);

    logic [OWN_W-1:0]     rd_ptr_q, wr_ptr_q;
    logic [OWN_W:0]       count_q;
    logic                 lock_q, lock_owner_q;
    logic [MAX_OUTST-1:0] owner_fifo_q;

    logic gnt, req_g, full, accept, pop, pop_owner;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_q;

    always_comb begin
        if (lock_q) begin
            gnt = lock_owner_q;
        end else if (m0_req && m1_req) begin
            gnt = ~rr_last_q;
        end else begin
            gnt = m1_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else if (accept) begin
            rr_last_q <= gnt;
        end
    end
`else
    always_comb begin
        if (lock_q) begin
            gnt = lock_owner_q;
        end else begin
            gnt = m1_req;
        end
    end
`endif

    assign req_g  = gnt ? m1_req : m0_req;
    // Full is a registered compare, so a same-cycle pop cannot unblock a request.
    assign full   = (count_q == FullCnt);
    assign s_req  = req_g & ~full & ~rst;
    assign accept = s_req & s_addr_ok;
    assign pop    = s_data_ok & (count_q != '0) & ~rst;

    assign pop_owner = owner_fifo_q[rd_ptr_q];

    assign s_wr    = gnt ? m1_wr    : m0_wr;
    assign s_size  = gnt ? m1_size  : m0_size;
    assign s_addr  = gnt ? m1_addr  : m0_addr;
    assign s_wdata = gnt ? m1_wdata : m0_wdata;
    assign s_wstrb = gnt ? m1_wstrb : m0_wstrb;

    assign m0_addr_ok = accept & ~gnt;
    assign m1_addr_ok = accept & gnt;
    assign m0_data_ok = pop & ~pop_owner;
    assign m1_data_ok = pop & pop_owner;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    assign busy = ~rst & ((count_q != '0) | m0_req | m1_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            owner_fifo_q <= '0;
        end else begin
            if (accept) begin
                lock_q                 <= 1'b0;
                owner_fifo_q[wr_ptr_q] <= gnt;
                wr_ptr_q               <= wr_ptr_q + 1'b1;
            end else if (s_req) begin
                lock_q       <= 1'b1;
                lock_owner_q <= gnt;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (accept && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !accept) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter (MAX_OUTST=4).
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size, s_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic        s_req, s_wr, s_addr_ok, s_data_ok, busy;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTST(4), .OWN_W(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge; checks follow #1 later, well before the rising edge.
    task automatic drive(input logic r0, input logic r1, input logic aok, input logic dok,
                         input logic [31:0] rdata);
        @(negedge clk);
        m0_req    = r0;
        m1_req    = r1;
        s_addr_ok = aok;
        s_data_ok = dok;
        s_rdata   = rdata;
        #1;
    endtask

    // {m1_data_ok, m0_data_ok, m1_addr_ok, m0_addr_ok, s_req}
    function automatic logic [31:0] flags();
        return {27'd0, m1_data_ok, m0_data_ok, m1_addr_ok, m0_addr_ok, s_req};
    endfunction

    initial begin
        rst = 1'b1;
        m0_wr = 1'b0; m0_size = 2'd2; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_wr = 1'b1; m1_size = 2'd1; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'h3;
        m0_addr = 32'h100; m1_addr = 32'h200;
        m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h0;
        #1;
        check("reset_flags", flags(), 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_flags", flags(), 32'h0);

        // Both request together
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
        check("both_first_addr", s_addr, 32'h100);
        check("both_first_flags", flags(), 32'b00011);
`else
        check("both_first_addr", s_addr, 32'h200);
        check("both_first_flags", flags(), 32'b00101);
        check("both_first_wdata", s_wdata, 32'hCAFE_F00D);
        check("both_first_ctl", {25'd0, s_wr, s_size, s_wstrb}, {25'd0, 1'b1, 2'd1, 4'h3});
`endif
`ifdef ARB_ROUND_ROBIN_EN
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("both_second_addr", s_addr, 32'h200);
        check("both_second_flags", flags(), 32'b00101);
`else
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("both_second_addr", s_addr, 32'h100);
        check("both_second_flags", flags(), 32'b00011);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
`ifdef ARB_ROUND_ROBIN_EN
        check("both_resp1", flags(), 32'b01000);
`else
        check("both_resp1", flags(), 32'b10000);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
`ifdef ARB_ROUND_ROBIN_EN
        check("both_resp2", flags(), 32'b10000);
`else
        check("both_resp2", flags(), 32'b01000);
`endif

        // Lock held against m1 while m0 waits for acceptance
        m0_addr = 32'h1000; m1_addr = 32'h2000;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("lock_c1_addr", s_addr, 32'h1000);
        check("lock_c1_flags", flags(), 32'b00001);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("lock_c2_addr", s_addr, 32'h1000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("lock_c3_addr", s_addr, 32'h1000);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("lock_c4_addr", s_addr, 32'h1000);
        check("lock_c4_flags", flags(), 32'b00011);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("lock_c5_addr", s_addr, 32'h2000);
        check("lock_c5_flags", flags(), 32'b00101);

        // In-order response routing
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0000);
        check("route_r1_flags", flags(), 32'b01000);
        check("route_r1_data", m0_rdata, 32'hAAAA_0000);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBBBB_0000);
        check("route_r2_flags", flags(), 32'b10000);
        check("route_r2_data", m1_rdata, 32'hBBBB_0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("route_idle_busy", {31'd0, busy}, 32'd0);

        // Fill to MAX_OUTST
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            check($sformatf("fill_%0d", i), flags(), 32'b00011);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("full_blocked", flags(), 32'b00000);
        check("full_busy", {31'd0, busy}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h33);
        check("full_pop_same_cycle", flags(), 32'b01000);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("full_unblocked", flags(), 32'b00011);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("drain_to_two", flags(), 32'b01000);

        // Simultaneous push and pop at count=2 (owners 0,0 -> 0,1)
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h55);
        check("pushpop_flags", flags(), 32'b01101);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h66);
        check("pushpop_r1", flags(), 32'b01000);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
        check("pushpop_r2", flags(), 32'b10000);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h88);
        check("spurious_resp", flags(), 32'b00000);

        // Reset mid-stream with count=3 and m1 locked
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_reset_lock", flags(), 32'b00001);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        rst = 1'b1;
        #1;
        check("midrst_flags", flags(), 32'b00000);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
        check("post_rst_stray", flags(), 32'b00000);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("post_rst_unlocked", s_addr, 32'h1000);
        check("post_rst_req", flags(), 32'b00001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Two-to-one arbiter sharing one SRAM-like cache/bridge port between the instruction-fetch master (m0) and the data master (m1).
- Sits between the CPU core and the cache/AXI bridge.
- Selects one request per cycle and locks the grant until the request is accepted.
- Keeps an in-order owner FIFO of accepted transactions so each data_ok/rdata is routed to the master that issued it.

Parameters:
- MAX_OUTST, 4, maximum accepted-but-not-returned transactions; power of two, 2..16.
- OWN_W, 2, log2(MAX_OUTST); owner FIFO pointer width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- m0_req  in  1  master 0 (instruction) request.
- m0_wr  in  1  m0 write.
- m0_size  in  2  m0 access size.
- m0_addr  in  32  m0 address.
- m0_wdata  in  32  m0 write data.
- m0_wstrb  in  4  m0 byte strobes.
- m0_rdata  out  32  m0 read data.
- m0_addr_ok  out  1  m0 request accepted.
- m0_data_ok  out  1  m0 response.
- m1_req, m1_wr, m1_size, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_addr_ok, m1_data_ok: same as m0, for master 1 (data).
- s_req  out  1  downstream request.
- s_wr  out  1  downstream write.
- s_size  out  2  downstream access size.
- s_addr  out  32  downstream address.
- s_wdata  out  32  downstream write data.
- s_wstrb  out  4  downstream byte strobes.
- s_rdata  in  32  downstream read data.
- s_addr_ok  in  1  downstream accept.
- s_data_ok  in  1  downstream response.
- busy  out  1  FIFO non-empty or request pending.

Behaviour:
- Reset: asynchronous, active-high. Clears FIFO rd/wr pointers, count=0, lock=0, lock_owner=0, rr_last=1. While rst=1, s_req, all addr_ok, all data_ok and busy are 0.
- Grant (combinational):
  - If lock=1: gnt=lock_owner.
  - Else if m1_req: gnt=1 (data master has priority).
  - Else if m0_req: gnt=0.
  - Else: gnt=0 with no request.
- s_req = req[gnt] & (count != MAX_OUTST). s_wr, s_size, s_addr, s_wdata, s_wstrb are muxed from the granted master.
- m<g>_addr_ok = s_addr_ok & s_req & (gnt==g). The other master's addr_ok is 0.
- Lock:
  - s_req & !s_addr_ok at the clock edge: lock<=1, lock_owner<=gnt.
  - s_addr_ok & s_req: lock<=0.
  - A locked request is never preempted, including when the other master raises req.
- Push: on (s_req & s_addr_ok), owner FIFO[wr]<=gnt, wr++ (wraps mod MAX_OUTST).
- Pop: on s_data_ok with count>0, owner=FIFO[rd], rd++. m<owner>_data_ok=1 in the same cycle (zero added latency). s_rdata goes to both m0_rdata and m1_rdata unmodified.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count==MAX_OUTST): s_req=0 and no addr_ok. lock is retained. A pop in the same cycle does not unblock until the next cycle (full is a registered count compare).
- Spurious s_data_ok with count==0: ignored, no master data_ok, pointers unchanged.
- busy = (count!=0) | m0_req | m1_req.
- Latency: arbiter adds 0 cycles on request and response paths. All outputs are combinational from inputs plus registered state.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: fixed priority is replaced by round-robin. When unlocked and both masters request, gnt = ~rr_last. rr_last<=gnt on every accept. Single requester wins immediately.
- Undefined: fixed priority, m1 over m0. The rr_last register is not instantiated.

Test Plan:
- Both req=1 in the same cycle, s_addr_ok=1 → m1_addr_ok=1, m0_addr_ok=0. Next cycle m0 is granted. With ARB_ROUND_ROBIN_EN and rr_last=1 after reset → m0 granted first.
- m0_req=1, s_addr_ok=0 for 3 cycles, m1_req rises in cycle 2 → s_addr stays m0_addr through acceptance in cycle 4, then m1 is granted.
- Accept m0@0x1000, then m1@0x2000, then s_data_ok twice with rdata 0xAAAA0000 and 0xBBBB0000 → m0_data_ok with 0xAAAA0000, then m1_data_ok with 0xBBBB0000.
- MAX_OUTST=4, four accepts with no data_ok → count=4. Fifth request: s_req=0. One data_ok → next cycle s_req=1 is accepted.
- Accept and data_ok in the same cycle at count=2 → count stays 2, correct owner routed.
- Assert rst mid-stream with count=3 and lock=1 → all outputs 0 immediately. After release: count=0, a stray s_data_ok produces no master data_ok.
